// File: rtl/pin_pulse_gen.sv
// Turns a fine-timed pulse request (start slot + length in slots) into 8-slot words for an 8:1 serializer.
// Optional pulse counter output enabled by defining PIN_PULSE_CNT_EN.
module pin_pulse_gen #(
  parameter int LEN_W   = 8,
  parameter int HOLDOFF = 2
) (
  input  logic             clk300,
  input  logic             rst,
  input  logic             str,
  input  logic [2:0]       ptime,
  input  logic [LEN_W-1:0] plen,
  output logic             rdy,
  output logic [7:0]       ser_word,
  output logic             busy
`ifdef PIN_PULSE_CNT_EN
  ,
  output logic [15:0]      pulse_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EMIT, HOLD} state_t;

  state_t         state, state_n;
  logic [LEN_W:0] rem, rem_n;
  logic [3:0]     hcnt, hcnt_n;
  logic [7:0]     word_n;
  logic [7:0]     first_word, tail_word;
  logic [LEN_W:0] pt_ext, len_ext, room, rem_first;
  logic           accept;

  assign accept = str && rdy && (plen != '0);

  // Extended width keeps ptime+plen and plen-(8-ptime) from wrapping.
  always_comb begin
    pt_ext    = (LEN_W+1)'(ptime);
    len_ext   = (LEN_W+1)'(plen);
    room      = (LEN_W+1)'(8) - pt_ext;
    rem_first = (len_ext > room) ? (len_ext - room) : '0;
    first_word = '0;
    tail_word  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      first_word[k] = ((LEN_W+1)'(k) >= pt_ext) && ((LEN_W+1)'(k) < (pt_ext + len_ext));
      tail_word[k]  = (LEN_W+1)'(k) < rem;
    end
  end

  // rem holds the slots still owed after the word currently on ser_word.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    hcnt_n  = hcnt;
    word_n  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = EMIT;
          word_n  = first_word;
          rem_n   = rem_first;
        end
      end
      EMIT: begin
        if (rem == '0) begin
          hcnt_n  = '0;
          state_n = (HOLDOFF == 0) ? IDLE : HOLD;
        end else if (rem >= (LEN_W+1)'(8)) begin
          word_n = '1;
          rem_n  = rem - (LEN_W+1)'(8);
        end else begin
          word_n = tail_word;
          rem_n  = '0;
        end
      end
      HOLD: begin
        if (int'(hcnt) + 1 >= HOLDOFF) state_n = IDLE;
        else                           hcnt_n  = hcnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk300 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      hcnt     <= '0;
      ser_word <= '0;
      rdy      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      hcnt     <= hcnt_n;
      ser_word <= word_n;
      rdy      <= (state_n == IDLE);
      busy     <= (state_n != IDLE);
    end
  end

`ifdef PIN_PULSE_CNT_EN
  always_ff @(posedge clk300 or posedge rst) begin
    if (rst)         pulse_cnt <= '0;
    else if (accept) pulse_cnt <= pulse_cnt + 16'd1;
  end
`endif

endmodule
